// File: rtl/dwc_upsample_arbiter_pkg.sv
// Shared types and helpers for the round-robin upsampling arbiter.
// Optional output skid register is enabled with DWC_ARB_OUT_REG_EN.
package dwc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int RR_MAX   = 32;
  localparam int RR_IDX_W = 5;

  typedef struct packed {
    logic                hit;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // Width helper that never returns zero, so single-value fields stay legal.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // First requester after 'last', wrapping modulo n; 'last' itself is checked last.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] req,
                                       input int last,
                                       input int n);
    rr_pick_t r;
    int       cand;
    r = '0;
    for (int k = 1; k <= RR_MAX; k++) begin
      if (k <= n) begin
        cand = last + k;
        if (cand >= n) cand = cand - n;
        if (!r.hit && req[cand[RR_IDX_W-1:0]]) begin
          r.hit = 1'b1;
          r.idx = cand[RR_IDX_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dwc_upsample_arbiter_if.sv
// Producer-side and converter-side AXI-Stream signals of the arbiter.
// slave: the arbiter's view; master: the surrounding environment's view.
interface dwc_upsample_arbiter_if #(
  parameter int N_INPUTS = 2,
  parameter int IN_WIDTH = 8,
  parameter int ID_WIDTH = 1
);
  logic [N_INPUTS*IN_WIDTH-1:0] s_axis_input_tdata;
  logic [N_INPUTS-1:0]          s_axis_input_tvalid;
  logic [N_INPUTS-1:0]          s_axis_input_tready;
  logic [IN_WIDTH-1:0]          m_axis_output_tdata;
  logic                         m_axis_output_tvalid;
  logic                         m_axis_output_tready;
  logic [ID_WIDTH-1:0]          m_axis_output_tid;

  modport slave (
    input  s_axis_input_tdata, s_axis_input_tvalid, m_axis_output_tready,
    output s_axis_input_tready, m_axis_output_tdata, m_axis_output_tvalid,
    output m_axis_output_tid
  );

  modport master (
    output s_axis_input_tdata, s_axis_input_tvalid, m_axis_output_tready,
    input  s_axis_input_tready, m_axis_output_tdata, m_axis_output_tvalid,
    input  m_axis_output_tid
  );
endinterface

// File: rtl/dwc_upsample_arbiter_skid.sv
// Two-entry skid buffer: registered valid/data and a registered upstream ready.
// Used by dwc_upsample_arbiter only when DWC_ARB_OUT_REG_EN is defined.
module dwc_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] s_data_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [WIDTH-1:0] m_data_o,
  output logic             m_valid_o,
  input  logic             m_ready_i
);
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;

  assign s_ready_o = ~skid_valid_q;
  assign m_valid_o = out_valid_q;
  assign m_data_o  = out_data_q;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (m_ready_i || !out_valid_q) begin
      // Output slot frees up: the parked word goes first, upstream is held off.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = s_valid_i;
        out_data_d  = s_data_i;
      end
    end else if (s_valid_i && !skid_valid_q) begin
      skid_valid_d = 1'b1;
      skid_data_d  = s_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end
endmodule

// File: rtl/dwc_upsample_arbiter.sv
// Round-robin arbiter granting one producer per converter output word (BEATS beats).
// Define DWC_ARB_OUT_REG_EN to register the converter-side outputs through a skid buffer.
module dwc_upsample_arbiter
  import dwc_pkg::*;
#(
  parameter int N_INPUTS  = 2,
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 32
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  dwc_upsample_arbiter_if.slave  bus,
  output logic                   busy
);
  localparam int BEATS     = OUT_WIDTH / IN_WIDTH;
  localparam int ID_WIDTH  = clog2_min1(N_INPUTS);
  localparam int CNT_WIDTH = clog2_min1(BEATS + 1);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(BEATS - 1);

  arb_state_t            state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_q, grant_d;
  logic [ID_WIDTH-1:0]   last_q, last_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  logic [IN_WIDTH-1:0]   src_data [N_INPUTS];
  logic [N_INPUTS-1:0]   sel;
  logic [N_INPUTS-1:0]   s_tready;
  logic [IN_WIDTH-1:0]   arb_tdata;
  logic                  arb_tvalid;
  logic                  arb_tready;
  logic [ID_WIDTH-1:0]   arb_tid;
  logic                  hs;

  logic [RR_MAX-1:0]     req_all, req_others;
  rr_pick_t              pick_idle, pick_next;
  logic [ID_WIDTH-1:0]   idle_idx, next_idx;

  genvar gi;
  generate
    for (gi = 0; gi < N_INPUTS; gi++) begin : g_src
      assign src_data[gi] = bus.s_axis_input_tdata[gi*IN_WIDTH +: IN_WIDTH];
      assign sel[gi]      = (state_q == BURST) && (grant_q == ID_WIDTH'(gi));
      assign s_tready[gi] = sel[gi] & arb_tready;
    end
  endgenerate

  always_comb begin
    req_all                 = '0;
    req_all[N_INPUTS-1:0]   = bus.s_axis_input_tvalid;
  end
  assign req_others = req_all & ~(RR_MAX'(1) << grant_q);
  assign pick_idle  = rr_pick(req_all, int'(last_q), N_INPUTS);
  assign pick_next  = rr_pick(req_others, int'(grant_q), N_INPUTS);

  always_comb begin
    idle_idx = '0;
    next_idx = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (pick_idle.idx == RR_IDX_W'(i)) idle_idx = ID_WIDTH'(i);
      if (pick_next.idx == RR_IDX_W'(i)) next_idx = ID_WIDTH'(i);
    end
  end

  always_comb begin
    arb_tdata  = '0;
    arb_tvalid = 1'b0;
    arb_tid    = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (sel[i]) begin
        arb_tdata  = src_data[i];
        arb_tvalid = bus.s_axis_input_tvalid[i];
        arb_tid    = grant_q;
      end
    end
  end
  assign hs = arb_tvalid & arb_tready;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (pick_idle.hit) begin
          grant_d = idle_idx;
          count_d = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (hs) begin
          if (count_q == LAST_CNT) begin
            // Word complete: hand over without a bubble if anyone else is waiting.
            last_d  = grant_q;
            count_d = '0;
            if (pick_next.hit) begin
              grant_d = next_idx;
            end else begin
              state_d = IDLE;
            end
          end else begin
            count_d = count_q + CNT_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= ID_WIDTH'(N_INPUTS - 1);
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  assign bus.s_axis_input_tready = s_tready;
  assign busy                    = (state_q == BURST);

`ifdef DWC_ARB_OUT_REG_EN
  logic [IN_WIDTH+ID_WIDTH-1:0] skid_out;

  dwc_skid_buffer #(
    .WIDTH(IN_WIDTH + ID_WIDTH)
  ) u_skid (
    .clk_i     (ap_clk),
    .rst_ni    (ap_rst_n),
    .s_data_i  ({arb_tid, arb_tdata}),
    .s_valid_i (arb_tvalid),
    .s_ready_o (arb_tready),
    .m_data_o  (skid_out),
    .m_valid_o (bus.m_axis_output_tvalid),
    .m_ready_i (bus.m_axis_output_tready)
  );
  assign {bus.m_axis_output_tid, bus.m_axis_output_tdata} = skid_out;
`else
  assign arb_tready               = bus.m_axis_output_tready;
  assign bus.m_axis_output_tdata  = arb_tdata;
  assign bus.m_axis_output_tvalid = arb_tvalid;
  assign bus.m_axis_output_tid    = arb_tid;
`endif
endmodule

// File: tb/tb_dwc_upsample_arbiter.sv
// Scoreboard bench for dwc_upsample_arbiter (3 producers, 8-bit beats, 32-bit words).
// Random producers push expected beats per source; a monitor pops them on each output handshake.
module tb_dwc_upsample_arbiter;
  localparam int N   = 3;
  localparam int IW  = 8;
  localparam int OW  = 32;
  localparam int IDW = 2;
  localparam int BTS = OW / IW;
`ifdef DWC_ARB_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic [N-1:0]  src_valid = '0;
  logic [IW-1:0] src_data [N];
  logic          out_ready = 1'b0;
  int            cyc = 0;

  dwc_upsample_arbiter_if #(.N_INPUTS(N), .IN_WIDTH(IW), .ID_WIDTH(IDW)) bus ();

  assign bus.s_axis_input_tvalid  = src_valid;
  assign bus.s_axis_input_tdata   = {src_data[2], src_data[1], src_data[0]};
  assign bus.m_axis_output_tready = out_ready;

  dwc_upsample_arbiter #(.N_INPUTS(N), .IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .bus      (bus.slave),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Scoreboard state
  logic [IW-1:0] exp_q [N][$];
  int            exp_tid_q [$];
  bit            mon_en = 1'b0;
  bit            fair_en = 1'b0;
  int            first_hs = -1, last_hs = -1, hs_count = 0;
  int            beat_idx = 0, word_tid = 0;
  bit            prev_stall = 1'b0;
  logic [IW-1:0] prev_data = '0;
  logic [IDW-1:0] prev_tid = '0;

  initial begin : monitor
    int t;
    logic [IW-1:0] e;
    int et;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        beat_idx = 0; prev_stall = 1'b0;
        first_hs = -1; last_hs = -1; hs_count = 0;
      end else begin
        if (prev_stall) begin
          chk(bus.m_axis_output_tvalid == 1'b1, "hold_valid", bus.m_axis_output_tvalid, 1);
          chk(bus.m_axis_output_tdata == prev_data, "hold_data", bus.m_axis_output_tdata, prev_data);
          chk(bus.m_axis_output_tid == prev_tid, "hold_tid", bus.m_axis_output_tid, prev_tid);
        end
        chk($onehot0(bus.s_axis_input_tready), "tready_onehot", bus.s_axis_input_tready, 0);
        if (bus.m_axis_output_tvalid && out_ready) begin
          t = int'(bus.m_axis_output_tid);
          if (t >= N) begin
            chk(1'b0, "tid_range", t, N - 1);
          end else if (exp_q[t].size() == 0) begin
            chk(1'b0, "unexpected_beat", bus.m_axis_output_tdata, t);
          end else begin
            e = exp_q[t].pop_front();
            chk(bus.m_axis_output_tdata == e, "beat_data", bus.m_axis_output_tdata, e);
          end
          if (beat_idx == 0) begin
            word_tid = t;
            if (first_hs < 0) first_hs = cyc;
            if (fair_en) begin
              if (exp_tid_q.size() == 0) chk(1'b0, "rr_extra_word", t, 0);
              else begin
                et = exp_tid_q.pop_front();
                chk(t == et, "rr_grant", t, et);
              end
            end
          end else begin
            chk(t == word_tid, "burst_tid", t, word_tid);
          end
          last_hs  = cyc;
          hs_count = hs_count + 1;
          beat_idx = (beat_idx + 1) % BTS;
          if (beat_idx == 0) $display("word from source %0d completed at cycle %0d", t, cyc);
        end
        prev_stall = bus.m_axis_output_tvalid && !out_ready;
        prev_data  = bus.m_axis_output_tdata;
        prev_tid   = bus.m_axis_output_tid;
      end
    end
  end

  task automatic clear_queues();
    for (int i = 0; i < N; i++) exp_q[i].delete();
    exp_tid_q.delete();
  endtask

  task automatic do_reset();
    mon_en    = 1'b0;
    fair_en   = 1'b0;
    rst_n     = 1'b0;
    src_valid = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk(bus.s_axis_input_tready == '0, "rst_tready", bus.s_axis_input_tready, 0);
    chk(bus.m_axis_output_tvalid == 1'b0, "rst_tvalid", bus.m_axis_output_tvalid, 0);
    chk(busy == 1'b0, "rst_busy", busy, 0);
    chk(bus.m_axis_output_tid == '0, "rst_tid", bus.m_axis_output_tid, 0);
    rst_n = 1'b1;
    clear_queues();
    @(posedge clk); #1;
    mon_en = 1'b1;
  endtask

  // rprob < 0 toggles downstream ready every cycle; stall parks source 0 after two beats.
  task automatic run_traffic(input string name, input int w0, input int w1, input int w2,
                             input int vprob, input int rprob, input bit fixed,
                             input bit fair, input bit stall, output int start_cyc);
    int  rem [N];
    int  acc_n [N];
    bit  acc [N];
    int  stall_left;
    int  guard;
    bit  in_stall;
    bit  done;
    $display("scenario %s", name);
    rem[0] = w0 * BTS; rem[1] = w1 * BTS; rem[2] = w2 * BTS;
    for (int i = 0; i < N; i++) begin acc_n[i] = 0; acc[i] = 1'b0; end
    stall_left = 6;
    guard      = 0;
    start_cyc  = -1;
    fair_en    = fair;
    if (fair)
      for (int k = 0; k < w0; k++)
        for (int i = 0; i < N; i++) exp_tid_q.push_back(i);
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++)
        if (src_valid[i] && acc[i]) begin
          src_valid[i] = 1'b0;
          rem[i]--;
          acc_n[i]++;
        end
      done = (rem[0] == 0) && (rem[1] == 0) && (rem[2] == 0);
      if (done) begin
        chk(busy == 1'b0, "busy_drop", busy, 0);
        break;
      end
      in_stall = stall && (acc_n[0] == 2) && (stall_left > 0) && !src_valid[0];
      for (int i = 0; i < N; i++)
        if (!src_valid[i] && rem[i] > 0 && !(in_stall && i == 0)
            && $urandom_range(99) < vprob) begin
          src_data[i] = fixed ? IW'(8'h11 * (acc_n[i] + 1)) : IW'($urandom);
          exp_q[i].push_back(src_data[i]);
          src_valid[i] = 1'b1;
          if (start_cyc < 0) start_cyc = cyc;
        end
      if (in_stall) stall_left--;
      if (rprob < 0) out_ready = ~out_ready;
      else           out_ready = ($urandom_range(99) < rprob);
      @(negedge clk);
      for (int i = 0; i < N; i++) acc[i] = src_valid[i] & bus.s_axis_input_tready[i];
      if (in_stall) begin
        chk(bus.s_axis_input_tready[2] == 1'b0, "stall_tready2", bus.s_axis_input_tready[2], 0);
        chk(busy == 1'b1, "stall_busy", busy, 1);
      end
      guard++;
      if (guard > 3000) begin
        chk(1'b0, "traffic_timeout", guard, 3000);
        break;
      end
    end
    out_ready = 1'b1;
    guard = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) == 0, "drain",
        exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);
    if (fair) chk(exp_tid_q.size() == 0, "rr_all_words", exp_tid_q.size(), 0);
    @(negedge clk);
    fair_en = 1'b0;
  endtask

  initial begin : main
    int s;
    int n_hs;
    int guard;
    for (int i = 0; i < N; i++) src_data[i] = '0;

    do_reset();
    run_traffic("single_source", 0, 1, 0, 100, 100, 1'b1, 1'b0, 1'b0, s);

    do_reset();
    run_traffic("all_valid", 3, 3, 3, 100, 100, 1'b0, 1'b1, 1'b0, s);
    chk(first_hs - s == LAT, "first_latency", first_hs - s, LAT);
    chk(hs_count == 9 * BTS, "beat_total", hs_count, 9 * BTS);
    chk(last_hs - first_hs + 1 == hs_count, "no_bubble", last_hs - first_hs + 1, hs_count);

    do_reset();
    run_traffic("stall", 1, 0, 1, 100, 100, 1'b0, 1'b0, 1'b1, s);

    do_reset();
    run_traffic("ready_toggle", 2, 2, 2, 100, -1, 1'b0, 1'b0, 1'b0, s);

    do_reset();
    for (int r = 0; r < 3; r++)
      run_traffic("random", 5, 4, 6, 60, 70, 1'b0, 1'b0, 1'b0, s);

    // Asynchronous reset in the middle of a burst
    do_reset();
    mon_en = 1'b0;
    for (int i = 0; i < N; i++) src_data[i] = IW'($urandom);
    src_valid = '1;
    out_ready = 1'b1;
    n_hs  = 0;
    guard = 0;
    while (n_hs < 2 && guard < 20) begin
      @(negedge clk);
      if (bus.m_axis_output_tvalid && out_ready) n_hs++;
      guard++;
    end
    chk(n_hs == 2, "async_setup", n_hs, 2);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk(bus.s_axis_input_tready == '0, "async_tready", bus.s_axis_input_tready, 0);
    chk(bus.m_axis_output_tvalid == 1'b0, "async_tvalid", bus.m_axis_output_tvalid, 0);
    chk(busy == 1'b0, "async_busy", busy, 0);
    src_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_queues();
    @(posedge clk); #1;
    mon_en = 1'b1;
    run_traffic("after_async_reset", 1, 1, 1, 100, 100, 1'b0, 1'b1, 1'b0, s);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
